draw_scheduler: RTL and testbench
=================================

DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 SHALL have parameter NREQ, default 5, number of drawing requesters (0=clear, 1=graph, 2=dash, 3=fill, 4=part).
REQ-002 SHALL have parameter X_W, default 8, pixel x width.
REQ-003 SHALL have parameter Y_W, default 7, pixel y width.
REQ-004 SHALL have parameter MAX_PIX, default 19200, watchdog pixel limit per grant.
REQ-005 SHALL have port clk  in  1  single system clock, all logic on rising edge.
REQ-006 SHALL have port resetn  in  1  asynchronous active-low reset.
REQ-007 SHALL have port req  in  NREQ  per-requester draw request, level.
REQ-008 SHALL have port pix_valid  in  NREQ  requester pixel valid.
REQ-009 SHALL have port pix_last  in  NREQ  final pixel of the figure, qualified by pix_valid.
REQ-010 SHALL have port pix_x  in  NREQ*X_W  flattened x coordinates, requester i at [i*X_W +: X_W].
REQ-011 SHALL have port pix_y  in  NREQ*Y_W  flattened y coordinates.
REQ-012 SHALL have port pix_color  in  NREQ*3  flattened 3-bit colours.
REQ-013 SHALL have port gnt  out  NREQ  one-hot grant.
REQ-014 SHALL have port done  out  NREQ  one-cycle completion pulse.
REQ-015 SHALL have ports plot (out, 1), x (out, X_W), y (out, Y_W), color (out, 3), all driving the VGA adapter.
REQ-016 SHALL have ports busy (out, 1), a grant is active, and wd_err (out, 1), one-cycle watchdog pulse.

Function
REQ-017 SHALL use FSM states IDLE, ARB, DRAW, RELEASE.
REQ-018 IDLE -> ARB when any req bit is high; otherwise remain in IDLE.
REQ-019 ARB SHALL pick one requester (fixed priority, lowest index wins), set gnt one-hot, clear pixel counter, then go to DRAW; latency from req to gnt is 2 cycles.
REQ-020 In DRAW, when pix_valid[g] is high, the block SHALL register plot=1, x, y and color from requester g on the next edge; plot is 0 in all other cycles.
REQ-021 Valid bits of non-granted requesters SHALL be ignored.
REQ-022 In DRAW, pix_valid[g] together with pix_last[g] SHALL move the FSM to RELEASE; the last pixel is still plotted.
REQ-023 RELEASE SHALL drop gnt, pulse done[g] for one cycle, then go to IDLE, giving a dead cycle between grants.
REQ-024 A requester that deasserts req during DRAW SHALL be released via RELEASE without a done pulse.
REQ-025 The pixel counter SHALL be 16 bits and saturating; reaching MAX_PIX without pix_last SHALL pulse wd_err, force RELEASE and suppress done.
REQ-026 busy SHALL be high in ARB, DRAW and RELEASE.
REQ-027 A new req arriving during DRAW SHALL wait; the grant is never preempted, including by clear.

Reset
REQ-028 resetn low SHALL asynchronously force IDLE, with gnt=0, done=0, plot=0, x=0, y=0, color=0, busy=0, wd_err=0, counter=0 and RR pointer=0.
REQ-029 Reset mid-DRAW SHALL abandon the figure with no done pulse; after release, arbitration restarts from priority order.

Configuration
REQ-030 Macro DRAW_SCHEDULER_RR_EN defined: ARB SHALL use round-robin, searching from the index after the last granted requester.
REQ-031 Macro DRAW_SCHEDULER_RR_EN undefined: ARB SHALL use fixed priority, the pointer logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-032 A shared package draw_pkg SHALL hold the FSM state enum, the requester index constants (REQ_CLEAR..REQ_PART) and the colour constants (BLACK=3'b000, BLUE=3'b001, GREEN=3'b010, RED=3'b100, WHITE=3'b111).
REQ-033 The arbitration logic SHALL be one sub-module, draw_arb (req, pointer -> one-hot grant).

Verification
REQ-034 Reset: resetn=0 mid-DRAW -> all outputs 0 within the same cycle; FSM in IDLE.
REQ-035 Priority: req=5'b10110 together -> gnt=5'b00010 first, then 5'b00100, then 5'b10000 (fixed priority).
REQ-036 Single figure: dash draws 11 pixels, last on pixel 11 -> 11 plot cycles with matching x/y/color, then done[2] pulse, then gnt=0.
REQ-037 Watchdog: with MAX_PIX=16, graph never asserts last -> wd_err after 16 pixels, no done[1], FSM returns to IDLE.
REQ-038 Abort: part drops req after 3 pixels -> RELEASE, no done[4], next requester granted.
REQ-039 RR (macro defined): clear and part both hold req -> grants alternate 0, 4, 0, 4.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared types and constants for the draw scheduler: FSM states, requester
// indices, VGA colours and an index-width helper.
package draw_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARB     = 2'd1,
        DRAW    = 2'd2,
        RELEASE = 2'd3
    } draw_state_e;

    localparam int REQ_CLEAR = 0;
    localparam int REQ_GRAPH = 1;
    localparam int REQ_DASH  = 2;
    localparam int REQ_FILL  = 3;
    localparam int REQ_PART  = 4;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] BLUE  = 3'b001;
    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] WHITE = 3'b111;

    // Index width that stays at least one bit for a single requester.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/draw_arb.sv
// Requester arbiter: scans req starting at ptr_i and grants the first one found.
// A constant zero pointer turns it into a plain lowest-index-wins priority encoder.
module draw_arb
    import draw_pkg::*;
#(
    parameter int NREQ = 5,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o
);

    logic found;
    int   cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int off = 0; off < NREQ; off++) begin
            cand = (int'(ptr_i) + off) % NREQ;
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                gnt_o[cand]  = 1'b1;
                idx_o        = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/draw_scheduler.sv
// Grants one drawing requester at a time access to the VGA adapter and forwards
// its pixels. Define DRAW_SCHEDULER_RR_EN for round-robin instead of fixed priority.
module draw_scheduler
    import draw_pkg::*;
#(
    parameter int NREQ    = 5,
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int MAX_PIX = 19200
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     pix_valid,
    input  logic [NREQ-1:0]     pix_last,
    input  logic [NREQ*X_W-1:0] pix_x,
    input  logic [NREQ*Y_W-1:0] pix_y,
    input  logic [NREQ*3-1:0]   pix_color,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic                plot,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [2:0]          color,
    output logic                busy,
    output logic                wd_err
);

    localparam int         IW        = idx_w(NREQ);
    localparam logic [15:0] MAX_PIX_C = (MAX_PIX > 65535) ? 16'hFFFF : 16'(MAX_PIX);

    draw_state_e     state_q;
    logic [NREQ-1:0] gnt_q, done_q;
    logic [IW-1:0]   gidx_q;
    logic [15:0]     cnt_q, cnt_d;
    logic            plot_q, wd_err_q;
    logic [X_W-1:0]  x_q;
    logic [Y_W-1:0]  y_q;
    logic [2:0]      color_q;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx, arb_ptr;
    logic            sel_valid, sel_last, sel_req;

`ifdef DRAW_SCHEDULER_RR_EN
    logic [IW-1:0] ptr_q;
    assign arb_ptr = ptr_q;
`else
    assign arb_ptr = '0;
`endif

    draw_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req_i (req),
        .ptr_i (arb_ptr),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    assign sel_valid = pix_valid[gidx_q];
    assign sel_last  = pix_last[gidx_q];
    assign sel_req   = req[gidx_q];
    assign cnt_d     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            done_q   <= '0;
            gidx_q   <= '0;
            cnt_q    <= '0;
            plot_q   <= 1'b0;
            wd_err_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            color_q  <= '0;
`ifdef DRAW_SCHEDULER_RR_EN
            ptr_q    <= '0;
`endif
        end else begin
            plot_q   <= 1'b0;
            done_q   <= '0;
            wd_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req) state_q <= ARB;
                end
                ARB: begin
                    cnt_q <= '0;
                    if (|req) begin
                        gnt_q   <= arb_gnt;
                        gidx_q  <= arb_idx;
                        state_q <= DRAW;
`ifdef DRAW_SCHEDULER_RR_EN
                        ptr_q   <= (int'(arb_idx) == NREQ - 1) ? '0 : arb_idx + 1'b1;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                DRAW: begin
                    if (sel_valid) begin
                        plot_q  <= 1'b1;
                        x_q     <= pix_x[int'(gidx_q)*X_W +: X_W];
                        y_q     <= pix_y[int'(gidx_q)*Y_W +: Y_W];
                        color_q <= pix_color[int'(gidx_q)*3 +: 3];
                        cnt_q   <= cnt_d;
                    end
                    // A final pixel wins over the watchdog, which wins over an abort.
                    if (sel_valid && sel_last) begin
                        gnt_q   <= '0;
                        done_q  <= gnt_q;
                        state_q <= RELEASE;
                    end else if (sel_valid && cnt_d == MAX_PIX_C) begin
                        gnt_q    <= '0;
                        wd_err_q <= 1'b1;
                        state_q  <= RELEASE;
                    end else if (!sel_req) begin
                        gnt_q   <= '0;
                        state_q <= RELEASE;
                    end
                end
                RELEASE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt    = gnt_q;
    assign done   = done_q;
    assign plot   = plot_q;
    assign x      = x_q;
    assign y      = y_q;
    assign color  = color_q;
    assign wd_err = wd_err_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_draw_scheduler.sv
// Self-checking bench for draw_scheduler: table-driven figures, hand-written
// arbitration/reset sequences and randomized multi-requester traffic.
module tb_draw_scheduler;
    import draw_pkg::*;

    localparam int N    = 5;
    localparam int XW   = 8;
    localparam int YW   = 7;
    localparam int MAXP = 16;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic [N-1:0]    req = '0, pix_valid = '0, pix_last = '0;
    logic [N*XW-1:0] pix_x = '0;
    logic [N*YW-1:0] pix_y = '0;
    logic [N*3-1:0]  pix_color = '0;
    logic [N-1:0]    gnt, done;
    logic            plot, busy, wd_err;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [2:0]      color;

    int checks = 0;
    int errors = 0;
    int modelPtr = 0;

    always #5 clk = ~clk;

    draw_scheduler #(.NREQ(N), .X_W(XW), .Y_W(YW), .MAX_PIX(MAXP)) dut (
        .clk(clk), .resetn(resetn), .req(req), .pix_valid(pix_valid),
        .pix_last(pix_last), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .gnt(gnt), .done(done), .plot(plot), .x(x), .y(y), .color(color),
        .busy(busy), .wd_err(wd_err)
    );

    typedef struct {
        int           idx;
        int           npix;
        int           abortAfter;
        logic [N-1:0] expDone;
        logic         expWd;
        int           expPlots;
    } figure_t;

    figure_t vecs[8];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int arbPtr();
`ifdef DRAW_SCHEDULER_RR_EN
        return modelPtr;
`else
        return 0;
`endif
    endfunction

    // Rotate the request mask so the search start sits at bit 0, isolate the
    // lowest set bit arithmetically, then rotate the answer back.
    function automatic int modelPick(input logic [N-1:0] m, input int p);
        logic [2*N-1:0] dbl;
        logic [N-1:0]   rot, low;
        int             pos;
        dbl = {m, m} >> p;
        rot = dbl[N-1:0];
        low = rot & (~rot + 1'b1);
        pos = 0;
        for (int b = 0; b < N; b++) if (low[b]) pos = b;
        return (pos + p) % N;
    endfunction

    task automatic outcomeModel(input int idx, input int npix, input int ab,
                                output logic [N-1:0] d, output logic w, output int p);
        d = '0; w = 1'b0;
        if (ab >= 0 && ab < MAXP && ab < npix) begin
            p = ab;
        end else if (npix <= MAXP) begin
            p = npix; d = onehot(idx);
        end else begin
            p = MAXP; w = 1'b1;
        end
    endtask

    task automatic applyStimulus(input int idx, input logic v, input logic l,
                                 input logic [XW-1:0] px, input logic [YW-1:0] py,
                                 input logic [2:0] pc);
        logic [N-1:0] jv, jl;
        jv = N'($urandom);
        jl = N'($urandom);
        jv[idx] = v;
        jl[idx] = l;
        for (int i = 0; i < N; i++) begin
            pix_x[i*XW +: XW]   = XW'($urandom);
            pix_y[i*YW +: YW]   = YW'($urandom);
            pix_color[i*3 +: 3] = 3'($urandom);
        end
        pix_x[idx*XW +: XW]   = px;
        pix_y[idx*YW +: YW]   = py;
        pix_color[idx*3 +: 3] = pc;
        pix_valid = jv;
        pix_last  = jl;
    endtask

    task automatic waitGrant(output int idx);
        int expIdx, lat;
        expIdx = modelPick(req, arbPtr());
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (gnt === '0 && lat < 8);
        checkOutput("grantLatency", lat, 2);
        checkOutput("grant", gnt, onehot(expIdx));
        idx = expIdx;
`ifdef DRAW_SCHEDULER_RR_EN
        modelPtr = (expIdx + 1) % N;
`endif
    endtask

    // Called on the negedge where the grant first shows; returns on the
    // negedge of the dead IDLE cycle that follows the release.
    task automatic drawGranted(input int idx, input int npix, input int abortAfter,
                               input logic [N-1:0] lateReq, input bit keepReq,
                               input logic [N-1:0] expDone, input logic expWd,
                               input int expPlots);
        int sent, plots, cyc;
        bit pend, ended;
        logic [XW-1:0] ex;
        logic [YW-1:0] ey;
        logic [2:0]    ec;
        sent = 0; plots = 0; cyc = 0; pend = 0; ended = 0;
        ex = '0; ey = '0; ec = '0;
        while (!ended && cyc < 200) begin
            cyc++;
            checkOutput("plot", plot, pend);
            if (pend) begin
                checkOutput("x", x, ex);
                checkOutput("y", y, ey);
                checkOutput("color", color, ec);
            end
            if (plot === 1'b1) plots++;
            checkOutput("gntHeld", gnt, onehot(idx));
            pend = 0;
            if (sent == abortAfter) begin
                req[idx] = 1'b0;
                applyStimulus(idx, 1'b0, 1'b0, '0, '0, '0);
                ended = 1;
            end else if ($urandom_range(0, 3) == 0) begin
                applyStimulus(idx, 1'b0, 1'($urandom), XW'($urandom), YW'($urandom), 3'($urandom));
            end else begin
                ex = XW'($urandom); ey = YW'($urandom); ec = 3'($urandom);
                sent++;
                applyStimulus(idx, 1'b1, (sent == npix), ex, ey, ec);
                pend = 1;
                if (sent == npix || sent == MAXP) ended = 1;
            end
            if (sent >= 1) req = req | lateReq;
            @(negedge clk);
        end
        checkOutput("drawTimeout", ended, 1);
        pix_valid = '0;
        pix_last  = '0;
        checkOutput("plot", plot, pend);
        if (pend) begin
            checkOutput("x", x, ex);
            checkOutput("y", y, ey);
            checkOutput("color", color, ec);
        end
        if (plot === 1'b1) plots++;
        checkOutput("relGnt", gnt, 0);
        checkOutput("relDone", done, expDone);
        checkOutput("relWd", wd_err, expWd);
        checkOutput("relBusy", busy, 1);
        if (!keepReq) req[idx] = 1'b0;
        @(negedge clk);
        checkOutput("idleBusy", busy, 0);
        checkOutput("idleDone", done, 0);
        checkOutput("idleWd", wd_err, 0);
        checkOutput("idleGnt", gnt, 0);
        checkOutput("idlePlot", plot, 0);
        checkOutput("plotCount", plots, expPlots);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "Gnt"}, gnt, 0);
        checkOutput({tag, "Done"}, done, 0);
        checkOutput({tag, "Plot"}, plot, 0);
        checkOutput({tag, "X"}, x, 0);
        checkOutput({tag, "Y"}, y, 0);
        checkOutput({tag, "Color"}, color, 0);
        checkOutput({tag, "Busy"}, busy, 0);
        checkOutput({tag, "Wd"}, wd_err, 0);
    endtask

    initial begin : main
        int g, npix, ab, p;
        logic [N-1:0] d, mask;
        logic w;

        vecs[0] = '{REQ_CLEAR, 1,  -1, 5'b00001, 1'b0, 1};
        vecs[1] = '{REQ_DASH,  11, -1, 5'b00100, 1'b0, 11};
        vecs[2] = '{REQ_GRAPH, 20, -1, 5'b00000, 1'b1, 16};
        vecs[3] = '{REQ_PART,  10, 3,  5'b00000, 1'b0, 3};
        vecs[4] = '{REQ_FILL,  16, -1, 5'b01000, 1'b0, 16};
        vecs[5] = '{REQ_FILL,  15, -1, 5'b01000, 1'b0, 15};
        vecs[6] = '{REQ_GRAPH, 17, -1, 5'b00000, 1'b1, 16};
        vecs[7] = '{REQ_CLEAR, 4,  0,  5'b00000, 1'b0, 0};

        repeat (2) @(negedge clk);
        checkAllZero("reset");
        resetn = 1'b1;
        @(negedge clk);
        checkAllZero("postReset");

`ifdef DRAW_SCHEDULER_RR_EN
        req = 5'b10001;
        for (int k = 0; k < 4; k++) begin
            waitGrant(g);
            checkOutput("rrGrant", gnt, (k % 2 == 0) ? 5'b00001 : 5'b10000);
            drawGranted(g, 2, -1, '0, 1'b1, onehot(g), 1'b0, 2);
        end
        req = '0;
        @(negedge clk);
`endif

        // Reset in the middle of a figure, then restart with simultaneous requests.
        req = onehot(REQ_FILL);
        waitGrant(g);
        applyStimulus(REQ_FILL, 1'b1, 1'b0, 8'h5A, 7'h33, RED);
        @(negedge clk);
        checkOutput("preResetPlot", plot, 1);
        checkOutput("preResetX", x, 8'h5A);
        resetn = 1'b0;
        #1;
        checkAllZero("midReset");
        modelPtr = 0;
        pix_valid = '0;
        req = 5'b10110;
        @(negedge clk);
        checkAllZero("heldReset");
        resetn = 1'b1;

        waitGrant(g);
        checkOutput("prioFirst", gnt, 5'b00010);
        drawGranted(g, 2, -1, '0, 1'b0, onehot(g), 1'b0, 2);
        waitGrant(g);
        checkOutput("prioSecond", gnt, 5'b00100);
        drawGranted(g, 3, -1, '0, 1'b0, onehot(g), 1'b0, 3);
        waitGrant(g);
        checkOutput("prioThird", gnt, 5'b10000);
        drawGranted(g, 1, -1, '0, 1'b0, onehot(g), 1'b0, 1);

        for (int i = 0; i < 8; i++) begin
            req = onehot(vecs[i].idx);
            waitGrant(g);
            drawGranted(g, vecs[i].npix, vecs[i].abortAfter, '0, 1'b0,
                        vecs[i].expDone, vecs[i].expWd, vecs[i].expPlots);
        end

        // Part aborts while clear arrives late; clear must wait, then get the grant.
        req = onehot(REQ_PART);
        waitGrant(g);
        drawGranted(g, 10, 3, onehot(REQ_CLEAR), 1'b0, '0, 1'b0, 3);
        waitGrant(g);
        checkOutput("abortNext", gnt, 5'b00001);
        drawGranted(g, 2, -1, '0, 1'b0, onehot(g), 1'b0, 2);

        for (int r = 0; r < 40; r++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            req = mask;
            while (req != '0) begin
                waitGrant(g);
                npix = $urandom_range(1, 20);
                ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, npix - 1) : -1;
                outcomeModel(g, npix, ab, d, w, p);
                drawGranted(g, npix, ab, '0, 1'b0, d, w, p);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL simTimeout actual=running expected=finished");
        $fatal(1, "[TB] simulation time limit");
    end

endmodule
